// File: rtl/datapath_dst_demux13.sv
// 1:3 packet demultiplexer: steers an upstream valid/ready stream to port A, B or C.
// Define DEMUX_BCAST_EN to make S==2'b11 broadcast each beat to all three ports.
module datapath_dst_demux13 #(
    parameter int DWID   = 24,
    parameter int CH_NUM = 8,
    parameter int LEN_W  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     S,
    input  logic [LEN_W-1:0]               pkt_len,
    input  logic                           Z_valid,
    output logic                           Z_ready,
    input  logic [CH_NUM-1:0][DWID-1:0]    Z_data,
    output logic                           A_valid,
    output logic                           B_valid,
    output logic                           C_valid,
    input  logic                           A_ready,
    input  logic                           B_ready,
    input  logic                           C_ready,
    output logic [CH_NUM-1:0][DWID-1:0]    A_data,
    output logic [CH_NUM-1:0][DWID-1:0]    B_data,
    output logic [CH_NUM-1:0][DWID-1:0]    C_data,
    output logic                           busy,
    output logic                           pkt_done
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [2:0]                    sel_q;
    logic [2:0]                    target;
    logic [2:0]                    slot_free;
    logic [2:0]                    out_valid;
    logic [2:0]                    out_ready;
    logic [CH_NUM-1:0][DWID-1:0]   out_data [3];
    logic [LEN_W-1:0]              len_q;
    logic [LEN_W-1:0]              cnt;
    logic                          hs;
    logic                          last;

    // One-hot destination mask, bit 0 = A, bit 1 = B, bit 2 = C.
    function automatic logic [2:0] decode(input logic [1:0] s);
        logic [2:0] d;
        d = s[1] ? 3'b100 : (s[0] ? 3'b010 : 3'b001);
`ifdef DEMUX_BCAST_EN
        if (s == 2'b11) d = 3'b111;
`endif
        return d;
    endfunction

    assign out_ready = {C_ready, B_ready, A_ready};
    assign slot_free = ~out_valid | out_ready;
    assign target    = (state == IDLE) ? decode(S) : sel_q;
    // Every selected destination must have room; unselected ones are masked off.
    assign Z_ready   = &(slot_free | ~target);
    assign hs        = Z_valid && Z_ready;
    assign last      = (state == IDLE) ? (pkt_len == '0) : (cnt == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (hs) state_nxt = last ? IDLE : BUSY;
    end

    always_comb begin
        busy = (state == BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= '0;
            len_q    <= '0;
            cnt      <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= hs && last;
            if (hs) begin
                if (state == IDLE) begin
                    if (!last) begin
                        sel_q <= decode(S);
                        len_q <= pkt_len;
                        cnt   <= LEN_W'(1);
                    end
                end else begin
                    cnt <= last ? '0 : cnt + LEN_W'(1);
                end
            end
        end
    end

    // Per-destination output stage: a load wins over a drain so beats stream back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            for (int i = 0; i < 3; i++) out_data[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (hs && target[i]) begin
                    out_valid[i] <= 1'b1;
                    out_data[i]  <= Z_data;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign A_valid = out_valid[0];
    assign B_valid = out_valid[1];
    assign C_valid = out_valid[2];
    assign A_data  = out_data[0];
    assign B_data  = out_data[1];
    assign C_data  = out_data[2];

endmodule

// File: tb/tb_datapath_dst_demux13.sv
// Directed bench for datapath_dst_demux13: vector table plus multi-cycle sequences.
module tb_datapath_dst_demux13;

    localparam int DWID   = 24;
    localparam int CH_NUM = 8;
    localparam int LEN_W  = 8;
    localparam int BW     = DWID * CH_NUM;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [1:0]                   s = '0;
    logic [LEN_W-1:0]             pkt_len = '0;
    logic                         z_valid = 1'b0;
    logic                         z_ready;
    logic [CH_NUM-1:0][DWID-1:0]  z_data = '0;
    logic                         a_valid, b_valid, c_valid;
    logic                         a_ready = 1'b0, b_ready = 1'b0, c_ready = 1'b0;
    logic [CH_NUM-1:0][DWID-1:0]  a_data, b_data, c_data;
    logic                         busy, pkt_done;

    int errors = 0;
    int checks = 0;

    datapath_dst_demux13 #(.DWID(DWID), .CH_NUM(CH_NUM), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .S(s), .pkt_len(pkt_len),
        .Z_valid(z_valid), .Z_ready(z_ready), .Z_data(z_data),
        .A_valid(a_valid), .B_valid(b_valid), .C_valid(c_valid),
        .A_ready(a_ready), .B_ready(b_ready), .C_ready(c_ready),
        .A_data(a_data), .B_data(b_data), .C_data(c_data),
        .busy(busy), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] s;
        logic [7:0] len;
        logic       zv;
        logic [7:0] zd;
        logic [2:0] rdy;   // {C,B,A}
        logic       zr;
        logic [2:0] vld;   // {C,B,A}
        logic [7:0] ad, bd, cd;
        logic       bsy, done;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [BW-1:0] rep(input logic [7:0] b);
        logic [BW-1:0] r;
        for (int i = 0; i < CH_NUM; i++) r[i*DWID +: DWID] = {16'h0, b};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sv, input logic [7:0] len, input logic zv,
                         input logic [7:0] zd, input logic [2:0] rdy);
        s = sv; pkt_len = len; z_valid = zv; z_data = rep(zd);
        {c_ready, b_ready, a_ready} = rdy;
    endtask

    int sent, recv, dones, cyc;
    logic drain;

    initial begin
        tbl[0]  = '{2'd1, 8'd0, 1'b1, 8'h11, 3'b010, 1'b1, 3'b010, 8'h00, 8'h11, 8'h00, 1'b0, 1'b1};
        tbl[1]  = '{2'd0, 8'd0, 1'b0, 8'h00, 3'b010, 1'b1, 3'b000, 8'h00, 8'h11, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{2'd0, 8'd3, 1'b1, 8'h21, 3'b001, 1'b1, 3'b001, 8'h21, 8'h11, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{2'd2, 8'd0, 1'b1, 8'h22, 3'b001, 1'b1, 3'b001, 8'h22, 8'h11, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{2'd2, 8'd0, 1'b1, 8'h23, 3'b001, 1'b1, 3'b001, 8'h23, 8'h11, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{2'd2, 8'd0, 1'b1, 8'h24, 3'b001, 1'b1, 3'b001, 8'h24, 8'h11, 8'h00, 1'b0, 1'b1};
        tbl[6]  = '{2'd2, 8'd0, 1'b0, 8'h00, 3'b001, 1'b1, 3'b000, 8'h24, 8'h11, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{2'd0, 8'd1, 1'b1, 8'h31, 3'b000, 1'b1, 3'b001, 8'h31, 8'h11, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{2'd2, 8'd0, 1'b1, 8'h32, 3'b000, 1'b0, 3'b001, 8'h31, 8'h11, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{2'd2, 8'd0, 1'b1, 8'h32, 3'b001, 1'b1, 3'b001, 8'h32, 8'h11, 8'h00, 1'b0, 1'b1};
        tbl[10] = '{2'd2, 8'd2, 1'b1, 8'h41, 3'b100, 1'b1, 3'b101, 8'h32, 8'h11, 8'h41, 1'b1, 1'b0};
        tbl[11] = '{2'd0, 8'd0, 1'b1, 8'h42, 3'b100, 1'b1, 3'b101, 8'h32, 8'h11, 8'h42, 1'b1, 1'b0};
        tbl[12] = '{2'd0, 8'd0, 1'b1, 8'h43, 3'b100, 1'b1, 3'b101, 8'h32, 8'h11, 8'h43, 1'b0, 1'b1};
        tbl[13] = '{2'd0, 8'd0, 1'b0, 8'h00, 3'b101, 1'b1, 3'b000, 8'h32, 8'h11, 8'h43, 1'b0, 1'b0};
        tbl[14] = '{2'd2, 8'd0, 1'b1, 8'h51, 3'b000, 1'b1, 3'b100, 8'h32, 8'h11, 8'h51, 1'b0, 1'b1};
        tbl[15] = '{2'd1, 8'd0, 1'b1, 8'h52, 3'b000, 1'b1, 3'b110, 8'h32, 8'h52, 8'h51, 1'b0, 1'b1};
        tbl[16] = '{2'd1, 8'd0, 1'b0, 8'h00, 3'b110, 1'b1, 3'b000, 8'h32, 8'h52, 8'h51, 1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst valids", BW'({c_valid, b_valid, a_valid}), BW'(3'b000));
        chk("rst busy", BW'(busy), BW'(0));
        chk("rst done", BW'(pkt_done), BW'(0));
        chk("rst a_data", a_data, '0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].s, tbl[i].len, tbl[i].zv, tbl[i].zd, tbl[i].rdy);
            #1;
            chk($sformatf("row%0d z_ready", i), BW'(z_ready), BW'(tbl[i].zr));
            tick();
            chk($sformatf("row%0d valids", i), BW'({c_valid, b_valid, a_valid}), BW'(tbl[i].vld));
            chk($sformatf("row%0d a_data", i), a_data, rep(tbl[i].ad));
            chk($sformatf("row%0d b_data", i), b_data, rep(tbl[i].bd));
            chk($sformatf("row%0d c_data", i), c_data, rep(tbl[i].cd));
            chk($sformatf("row%0d busy", i), BW'(busy), BW'(tbl[i].bsy));
            chk($sformatf("row%0d done", i), BW'(pkt_done), BW'(tbl[i].done));
        end

        // 16-beat packet to A under random A_ready stalls
        sent = 0; recv = 0; dones = 0; cyc = 0;
        while (recv < 16 && cyc < 300) begin
            drive(2'd0, 8'd15, sent < 16, 8'(sent + 1), {2'b11, 1'($urandom_range(0, 1))});
            #1;
            chk("stall z_ready", BW'(z_ready), BW'(!a_valid || a_ready));
            drain = a_valid && a_ready;
            if (drain) begin
                chk($sformatf("stall beat%0d", recv), a_data, rep(8'(recv + 1)));
                recv++;
            end
            if (z_valid && z_ready) sent++;
            tick();
            if (pkt_done) dones++;
            cyc++;
        end
        chk("stall beats drained", BW'(recv), BW'(16));
        chk("stall pkt_done count", BW'(dones), BW'(1));
        chk("stall busy end", BW'(busy), BW'(0));

        // Reset in the middle of an 8-beat packet to B
        drive(2'd1, 8'd7, 1'b1, 8'h61, 3'b111);
        tick();
        drive(2'd1, 8'd7, 1'b1, 8'h62, 3'b000);
        tick();
        chk("mid busy", BW'(busy), BW'(1));
        chk("mid b_valid", BW'(b_valid), BW'(1));
        rst = 1'b1;
        #1;
        chk("mrst valids", BW'({c_valid, b_valid, a_valid}), BW'(3'b000));
        chk("mrst busy", BW'(busy), BW'(0));
        rst = 1'b0;
        drive(2'd2, 8'd0, 1'b1, 8'h63, 3'b000);
        #1;
        chk("post z_ready", BW'(z_ready), BW'(1));
        tick();
        chk("post valids", BW'({c_valid, b_valid, a_valid}), BW'(3'b100));
        chk("post c_data", c_data, rep(8'h63));
        chk("post done", BW'(pkt_done), BW'(1));
        chk("post busy", BW'(busy), BW'(0));
        drive(2'd0, 8'd0, 1'b0, 8'h00, 3'b111);
        tick();

`ifdef DEMUX_BCAST_EN
        // Broadcast two-beat packet with C stalled after the first beat
        drive(2'd3, 8'd1, 1'b1, 8'h71, 3'b011);
        #1;
        chk("bc z_ready0", BW'(z_ready), BW'(1));
        tick();
        chk("bc valids0", BW'({c_valid, b_valid, a_valid}), BW'(3'b111));
        chk("bc data0", a_data ^ b_data ^ c_data, rep(8'h71));
        chk("bc b_data0", b_data, rep(8'h71));
        drive(2'd3, 8'd1, 1'b1, 8'h72, 3'b011);
        #1;
        chk("bc z_ready1", BW'(z_ready), BW'(0));
        tick();
        chk("bc valids1", BW'({c_valid, b_valid, a_valid}), BW'(3'b100));
        chk("bc c_hold", c_data, rep(8'h71));
        chk("bc z_ready2", BW'(z_ready), BW'(0));
        drive(2'd3, 8'd1, 1'b1, 8'h72, 3'b111);
        #1;
        chk("bc z_ready3", BW'(z_ready), BW'(1));
        tick();
        chk("bc valids2", BW'({c_valid, b_valid, a_valid}), BW'(3'b111));
        chk("bc a_data2", a_data, rep(8'h72));
        chk("bc b_data2", b_data, rep(8'h72));
        chk("bc c_data2", c_data, rep(8'h72));
        chk("bc done", BW'(pkt_done), BW'(1));
        drive(2'd0, 8'd0, 1'b0, 8'h00, 3'b111);
        tick();
        chk("bc drained", BW'({c_valid, b_valid, a_valid}), BW'(3'b000));
`else
        // Without broadcast, S==11 behaves as C only
        drive(2'd3, 8'd0, 1'b1, 8'h71, 3'b111);
        tick();
        chk("s11 valids", BW'({c_valid, b_valid, a_valid}), BW'(3'b100));
        chk("s11 c_data", c_data, rep(8'h71));
        chk("s11 done", BW'(pkt_done), BW'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
